// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer between the PC, instruction memory
// and decode. Keeps at most one fetch outstanding, advances the PC by one
// strobe per granted request, and buffers tagged responses in a small
// first-word-fall-through FIFO. A flush empties the FIFO and discards any
// response still in flight.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   pc_i                  current PC
//   incr_pc_o             PC advance strobe (one cycle per grant)
//   imem_req_o/addr_o     fetch request and address (addr is 0 when idle)
//   imem_gnt_i            memory accepts the request this cycle
//   imem_rvalid_i/rdata_i read response
//   instr_valid_o         FIFO head valid
//   instr_o, instr_pc_o   FIFO head instruction and its fetch address
//   instr_ready_i         decode consumes the head this cycle
//   flush_i               discard buffered and in-flight instructions
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | requesting at pc_i whenever the FIFO has room
// WAIT  | one fetch granted, waiting for its response
// DROP  | flushed while waiting; the pending response will be discarded
module fetch_ctrl #(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic        incr_pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        flush_i
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e          state_q;
    logic [31:0]     req_pc_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     buf_instr_q [BUF_DEPTH];
    logic [31:0]     buf_pc_q    [BUF_DEPTH];

    logic            push;
    logic            pop;

    // The request term is masked by rst_i so the outputs read idle while
    // reset is held, even though the reset state (REQ, empty) would request.
    assign imem_req_o    = !rst_i && (state_q == REQ) && (count_q < DEPTH_C) && !flush_i;
    assign incr_pc_o     = imem_req_o && imem_gnt_i;
    assign imem_addr_o   = imem_req_o ? pc_i : 32'h0;

    assign push          = (state_q == WAIT) && imem_rvalid_i && !flush_i;
    assign pop           = instr_valid_o && instr_ready_i && !flush_i;

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = buf_instr_q[rd_ptr_q];
    assign instr_pc_o    = buf_pc_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= REQ;
            req_pc_q <= 32'h0;
        end else begin
            case (state_q)
                REQ: begin
                    // A stray rvalid here is a protocol error and is ignored.
                    if (incr_pc_o) begin
                        req_pc_q <= pc_i;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= REQ;
                    end else if (flush_i) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rvalid_i) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once count says so.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata_i;
            buf_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    // Requests are only raised with room in the FIFO, so a push can never
    // land on a full buffer.
    a_no_push_when_full: assert property (
        @(posedge clk_i) disable iff (rst_i) !(push && (count_q == DEPTH_C))
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (BUF_DEPTH=2). The bench plays the PC block
// (pc_i advances by 4 after each cycle in which incr_pc_o was high) and the
// instruction memory (grant/rvalid driven explicitly per cycle).
module tb_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        incr_pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        flush_i;

    int errors = 0;
    int checks = 0;

    fetch_ctrl #(.BUF_DEPTH(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .incr_pc_o     (incr_pc_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .flush_i       (flush_i)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle's inputs at the falling edge and let outputs settle.
    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic fl);
        @(negedge clk_i);
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        instr_ready_i = rdy;
        flush_i       = fl;
        #1;
    endtask

    // Cross the rising edge; the PC block advances if a grant was taken.
    task automatic clk_edge();
        logic inc;
        inc = incr_pc_o;
        @(posedge clk_i);
        #1;
        if (inc) pc_i = pc_i + 32'd4;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; pc_i = 32'h0; flush_i = 1'b0;
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; instr_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
        checks++; if (incr_pc_o !== 1'b0) begin errors++; $display("FAIL rst_incr: got %b want 0", incr_pc_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
        @(negedge clk_i);
        rst_i = 1'b0; imem_gnt_i = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", imem_addr_o); end
        clk_edge();
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL stream_req[%0d]: got %b want 1", k, imem_req_o); end
            checks++; if (imem_addr_o !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr_o, 4 * k); end
            checks++; if (incr_pc_o !== 1'b1) begin errors++; $display("FAIL stream_incr[%0d]: got %b want 1", k, incr_pc_o); end
            if (k > 0) begin
                checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, instr_valid_o); end
                checks++; if (instr_pc_o !== 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, instr_pc_o, 4 * (k - 1)); end
                checks++; if (instr_o !== 32'hA000_0000 + 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_instr[%0d]: got %h", k, instr_o); end
            end
            clk_edge();
            cyc(1'b0, 1'b1, 32'hA000_0000 + 32'(4 * k), 1'b1, 1'b0);
            checks++; if (incr_pc_o !== 1'b0) begin errors++; $display("FAIL stream_incr_off[%0d]: got %b want 0", k, incr_pc_o); end
            checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stream_req_wait[%0d]: got %b want 0", k, imem_req_o); end
            clk_edge();
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (instr_pc_o !== 32'h8) begin errors++; $display("FAIL stream_last_pc: got %h want 8", instr_pc_o); end
        checks++; if (instr_o !== 32'hA000_0008) begin errors++; $display("FAIL stream_last_instr: got %h want a0000008", instr_o); end
        clk_edge();
    endtask

    task automatic test_backpressure();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (imem_addr_o !== 32'hC) begin errors++; $display("FAIL bp_addr0: got %h want c", imem_addr_o); end
        clk_edge();
        cyc(1'b0, 1'b1, 32'hD000_000C, 1'b0, 1'b0); clk_edge();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (imem_addr_o !== 32'h10) begin errors++; $display("FAIL bp_addr1: got %h want 10", imem_addr_o); end
        clk_edge();
        cyc(1'b0, 1'b1, 32'hD000_0010, 1'b0, 1'b0); clk_edge();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_req_full[%0d]: got %b want 0", i, imem_req_o); end
            checks++; if (incr_pc_o !== 1'b0) begin errors++; $display("FAIL bp_incr_full[%0d]: got %b want 0", i, incr_pc_o); end
            checks++; if (instr_pc_o !== 32'hC) begin errors++; $display("FAIL bp_head[%0d]: got %h want c", i, instr_pc_o); end
            clk_edge();
        end
        checks++; if (dut.count_q !== 2'd2) begin errors++; $display("FAIL bp_count_full: got %0d want 2", dut.count_q); end
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_req_drain: got %b want 0", imem_req_o); end
        checks++; if (instr_o !== 32'hD000_000C) begin errors++; $display("FAIL bp_drain0: got %h want d000000c", instr_o); end
        clk_edge();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL bp_req_resume: got %b want 1", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h14) begin errors++; $display("FAIL bp_addr_resume: got %h want 14", imem_addr_o); end
        checks++; if (instr_pc_o !== 32'h10) begin errors++; $display("FAIL bp_drain1_pc: got %h want 10", instr_pc_o); end
        checks++; if (instr_o !== 32'hD000_0010) begin errors++; $display("FAIL bp_drain1: got %h want d0000010", instr_o); end
        clk_edge();
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", instr_valid_o); end
    endtask

    task automatic test_gnt_wait();
        pc_i = 32'h100;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL gw_req[%0d]: got %b want 1", i, imem_req_o); end
            checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL gw_addr[%0d]: got %h want 100", i, imem_addr_o); end
            checks++; if (incr_pc_o !== 1'b0) begin errors++; $display("FAIL gw_incr[%0d]: got %b want 0", i, incr_pc_o); end
            clk_edge();
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (incr_pc_o !== 1'b1) begin errors++; $display("FAIL gw_incr_gnt: got %b want 1", incr_pc_o); end
        clk_edge();
        cyc(1'b0, 1'b1, 32'hB000_0100, 1'b1, 1'b0); clk_edge();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (instr_pc_o !== 32'h100) begin errors++; $display("FAIL gw_head_pc: got %h want 100", instr_pc_o); end
        checks++; if (instr_o !== 32'hB000_0100) begin errors++; $display("FAIL gw_head: got %h want b0000100", instr_o); end
        checks++; if (imem_addr_o !== 32'h104) begin errors++; $display("FAIL gw_next_addr: got %h want 104", imem_addr_o); end
        clk_edge();
    endtask

    task automatic test_flush_wait();
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0); clk_edge();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL fw_req: got %b want 0", imem_req_o); end
        clk_edge();
        checks++; if (2'(dut.state_q) !== 2'd2) begin errors++; $display("FAIL fw_drop: got %0d want 2", dut.state_q); end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); clk_edge();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL fw_req_drop: got %b want 0", imem_req_o); end
        clk_edge();
        checks++; if (2'(dut.state_q) !== 2'd2) begin errors++; $display("FAIL fw_drop_hold: got %0d want 2", dut.state_q); end
        cyc(1'b0, 1'b1, 32'hEEEE_EEEE, 1'b1, 1'b0); clk_edge();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL fw_valid: got %b want 0", instr_valid_o); end
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL fw_req_after: got %b want 1", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h108) begin errors++; $display("FAIL fw_addr_after: got %h want 108", imem_addr_o); end
        clk_edge();
    endtask

    task automatic test_flush_rvalid();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); clk_edge();
        cyc(1'b0, 1'b1, 32'hC000_0108, 1'b0, 1'b0); clk_edge();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (imem_addr_o !== 32'h10C) begin errors++; $display("FAIL fr_addr: got %h want 10c", imem_addr_o); end
        clk_edge();
        checks++; if (dut.count_q !== 2'd1) begin errors++; $display("FAIL fr_count_setup: got %0d want 1", dut.count_q); end
        cyc(1'b0, 1'b1, 32'hC000_010C, 1'b1, 1'b1); clk_edge();
        checks++; if (dut.count_q !== 2'd0) begin errors++; $display("FAIL fr_count: got %0d want 0", dut.count_q); end
        checks++; if (2'(dut.state_q) !== 2'd0) begin errors++; $display("FAIL fr_state: got %0d want 0", dut.state_q); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL fr_valid: got %b want 0", instr_valid_o); end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (imem_addr_o !== 32'h110) begin errors++; $display("FAIL fr_next_addr: got %h want 110", imem_addr_o); end
        clk_edge();
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); clk_edge();
        cyc(1'b0, 1'b1, 32'hF000_0110, 1'b0, 1'b0); clk_edge();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); clk_edge();
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL rm_setup_valid: got %b want 1", instr_valid_o); end
        @(negedge clk_i);
        rst_i = 1'b1; imem_gnt_i = 1'b1;
        #1;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", instr_valid_o); end
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rm_req: got %b want 0", imem_req_o); end
        checks++; if (incr_pc_o !== 1'b0) begin errors++; $display("FAIL rm_incr: got %b want 0", incr_pc_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h want 0", imem_addr_o); end
        checks++; if (2'(dut.state_q) !== 2'd0) begin errors++; $display("FAIL rm_state: got %0d want 0", dut.state_q); end
        clk_edge();
        @(negedge clk_i);
        rst_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; instr_ready_i = 1'b1;
        #1;
        checks++; if (imem_addr_o !== 32'h118) begin errors++; $display("FAIL rm_addr_after: got %h want 118", imem_addr_o); end
        clk_edge();
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rm_late_rvalid: got %b want 0", instr_valid_o); end
        checks++; if (2'(dut.state_q) !== 2'd0) begin errors++; $display("FAIL rm_state_after: got %0d want 0", dut.state_q); end
        imem_rvalid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_wait();
        test_flush_wait();
        test_flush_rvalid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
